decode_queue: RTL and testbench
===============================

Name: decode_queue

Overview:
- Registered RV32I decode stage for the out-of-order core, between the instruction fetch queue and the issue/dispatch logic.
- Decodes every instruction format fully, rather than the subset the current combinational decoder handles.
- Buffers decoded micro-ops in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Supports pipeline flush on mispredict and halt detection.

Parameters:
- DEPTH, 2: decoded-entry FIFO depth (power of two, ≥2).
- ADDR_W, 32: PC width.
- NAME_W, 6: operation-code width; codes are the const.v macros.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  reset, asynchronous, active-low (0 = reset).
- rdy_in  input  1  global enable; when 0, all state holds.
- flush_in  input  1  mispredict flush.
- in_valid  input  1  fetch offers an instruction.
- in_ready  output  1  queue can accept.
- in_inst  input  32  raw instruction.
- in_pc  input  ADDR_W  its PC.
- out_valid  output  1  head entry valid.
- out_ready  input  1  dispatch accepts head.
- out_pc  output  ADDR_W  head PC.
- out_name  output  NAME_W  operation code.
- out_type  output  2  REG/MEM/BR/DONE class.
- out_rd, out_rs1, out_rs2  output  5 each  register fields.
- out_imm  output  32  sign-extended immediate.
- out_is_imm, out_is_pc  output  1 each  operand-B-is-imm, operand-A-is-PC.
- out_illegal  output  1  undecodable instruction.
- out_halt  output  1  head is the halt instruction.

Behaviour:
- Reset (rst_in=0, asynchronous):
  - FIFO count, read/write pointers and halt_seen cleared.
  - out_valid=0, in_ready=1; all data outputs 0.
- rdy_in=0: no state changes; outputs hold.
- Enqueue:
  - Fires when in_valid && in_ready at the edge.
  - in_inst is decoded combinationally and written into the FIFO.
  - Latency 1: the entry is visible on out_* the cycle after acceptance if the FIFO was empty.
- Dequeue: fires when out_valid && out_ready. Head outputs are driven directly from the FIFO head register.
- in_ready = (count < DEPTH) && !halt_seen. There is no combinational path from out_ready to in_ready. Simultaneous enqueue and dequeue at count==DEPTH is not possible because in_ready is 0.
- Simultaneous enqueue and dequeue when 0<count<DEPTH: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- Immediates:
  - I-type (loads, OP-IMM, JALR): inst[31] replicated into [31:11], inst[30:20] in [10:0].
  - S-type: {inst[31:25], inst[11:7]}, sign-extended.
  - B-type: {inst[31], inst[7], inst[30:25], inst[11:8], 0}, sign-extended.
  - U-type (LUI, AUIPC): {inst[31:12], 12'b0}.
  - J-type (JAL): {inst[31], inst[19:12], inst[20], inst[30:21], 0}, sign-extended.
- Classes:
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR, loads: REG.
  - Stores: MEM.
  - Branches: BR.
  - is_pc=1 for AUIPC and JAL.
  - is_imm=1 for every format that carries an immediate, except branches.
- name: selected from funct3/funct7 for all 37 RV32I non-system operations. funct7[5] distinguishes SUB/SRA/SRAI.
- Illegal:
  - Triggers: unknown opcode, or a reserved funct3/funct7 combination.
  - Result: out_illegal=1, type REG, name ADD, rd=0, is_imm=0, so the entry acts as a NOP.
- Halt:
  - Trigger: in_inst==32'h0ff00513 is enqueued with type DONE and halt=1.
  - halt_seen is set, blocking further enqueues until flush or reset.
- Flush (synchronous):
  - Clears count, pointers and halt_seen.
  - An enqueue in the same cycle is discarded; a dequeue in the same cycle is also discarded.
  - out_valid=0 the next cycle.
  - Flush has priority over every other event.
- Reset asserted mid-operation: everything drops immediately, independent of the clock.

Optional Feature:
- Macro: DECODE_RV32M_EN.
- Defined: opcode 0110011 with funct7=0000001 decodes to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM or REMU (type REG, is_imm=0).
- Undefined: that encoding is illegal (out_illegal=1, NOP behaviour).

Test Plan:
- Reset, then enqueue 0x00500093 (addi x1,x0,5) at pc 0x0:
  - Next cycle: out_valid=1, name ADDI, rd=1, rs1=0, imm=5, is_imm=1.
  - Dequeue → out_valid=0.
- Hold out_ready=0 and offer 3 instructions with DEPTH=2:
  - in_ready drops after the 2nd is accepted and the 3rd stays pending.
  - Release out_ready → FIFO order preserved and the 3rd is accepted.
- Enqueue 0xfe000ee3 (beq x0,x0,-4) → type BR, imm=0xfffffffc, is_imm=0. Enqueue 0x008000ef (jal x1,8) → imm=8, is_pc=1, rd=1.
- Assert flush_in with count=2 and in_valid=1:
  - Next cycle: out_valid=0, in_ready=1.
  - The flushed-cycle instruction never appears on out_*.
- Enqueue 0x0ff00513:
  - Entry has type DONE, halt=1; in_ready=0 afterwards.
  - Flush restores in_ready=1.
- Enqueue 0x02208033 (mul x0,x1,x2):
  - With DECODE_RV32M_EN: name MUL, illegal=0.
  - Without: illegal=1, rd=0.

Source files
------------

// File: rtl/decode_queue.sv
// decode_queue
//   Registered RV32I decode stage. Fetched instructions are decoded
//   combinationally on entry and stored as micro-ops in a DEPTH-entry FIFO.
//   Both sides use valid/ready handshakes. Supports mispredict flush and
//   halt detection.
//
//   Optional feature: define DECODE_RV32M_EN to decode the RV32M
//   multiply/divide group. When undefined, that encoding decodes as illegal.
//
// Ports
//   clk_in      clock, rising edge
//   rst_in      asynchronous reset, active low
//   rdy_in      global enable; 0 holds all state
//   flush_in    mispredict flush (synchronous, highest priority)
//   in_valid    fetch offers in_inst / in_pc
//   in_ready    queue can accept (registered, no path from out_ready)
//   out_valid   head entry valid
//   out_ready   dispatch accepts the head
//   out_pc, out_name, out_type, out_rd, out_rs1, out_rs2, out_imm,
//   out_is_imm, out_is_pc, out_illegal, out_halt   head micro-op fields
//
// Name codes
//    0 ADD    1 SUB    2 SLL    3 SLT    4 SLTU   5 XOR    6 SRL    7 SRA
//    8 OR     9 AND   10 ADDI  11 SLTI  12 SLTIU 13 XORI  14 ORI   15 ANDI
//   16 SLLI  17 SRLI  18 SRAI  19 LB    20 LH    21 LW    22 LBU   23 LHU
//   24 SB    25 SH    26 SW    27 BEQ   28 BNE   29 BLT   30 BGE   31 BLTU
//   32 BGEU  33 LUI   34 AUIPC 35 JAL   36 JALR  37..44 MUL..REMU
// Type codes: 0 REG, 1 MEM, 2 BR, 3 DONE
//
// Register fields that a format does not use are reported as 0, so that
// dispatch never sees false dependencies.

module decode_queue #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32,
    parameter int NAME_W = 6
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [NAME_W-1:0] out_name,
    output logic [1:0]        out_type,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [31:0]       out_imm,
    output logic              out_is_imm,
    output logic              out_is_pc,
    output logic              out_illegal,
    output logic              out_halt
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_W + NAME_W + 2 + 15 + 32 + 4;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [31:0] HALT_INST = 32'h0ff00513;

    localparam logic [1:0] T_REG = 2'd0, T_MEM = 2'd1, T_BR = 2'd2, T_DONE = 2'd3;

    localparam logic [NAME_W-1:0]
        N_ADD  = NAME_W'(0),  N_SUB   = NAME_W'(1),  N_SLL   = NAME_W'(2),
        N_SLT  = NAME_W'(3),  N_SLTU  = NAME_W'(4),  N_XOR   = NAME_W'(5),
        N_SRL  = NAME_W'(6),  N_SRA   = NAME_W'(7),  N_OR    = NAME_W'(8),
        N_AND  = NAME_W'(9),  N_ADDI  = NAME_W'(10), N_SLTI  = NAME_W'(11),
        N_SLTIU= NAME_W'(12), N_XORI  = NAME_W'(13), N_ORI   = NAME_W'(14),
        N_ANDI = NAME_W'(15), N_SLLI  = NAME_W'(16), N_SRLI  = NAME_W'(17),
        N_SRAI = NAME_W'(18), N_LB    = NAME_W'(19), N_LH    = NAME_W'(20),
        N_LW   = NAME_W'(21), N_LBU   = NAME_W'(22), N_LHU   = NAME_W'(23),
        N_SB   = NAME_W'(24), N_SH    = NAME_W'(25), N_SW    = NAME_W'(26),
        N_BEQ  = NAME_W'(27), N_BNE   = NAME_W'(28), N_BLT   = NAME_W'(29),
        N_BGE  = NAME_W'(30), N_BLTU  = NAME_W'(31), N_BGEU  = NAME_W'(32),
        N_LUI  = NAME_W'(33), N_AUIPC = NAME_W'(34), N_JAL   = NAME_W'(35),
        N_JALR = NAME_W'(36);
`ifdef DECODE_RV32M_EN
    localparam logic [NAME_W-1:0]
        N_MUL  = NAME_W'(37), N_MULH  = NAME_W'(38), N_MULHSU = NAME_W'(39),
        N_MULHU= NAME_W'(40), N_DIV   = NAME_W'(41), N_DIVU   = NAME_W'(42),
        N_REM  = NAME_W'(43), N_REMU  = NAME_W'(44);
`endif

    // ---------------------------------------------------------------- decode
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];
    assign imm_i  = {{21{in_inst[31]}}, in_inst[30:20]};
    assign imm_s  = {{21{in_inst[31]}}, in_inst[30:25], in_inst[11:7]};
    assign imm_b  = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u  = {in_inst[31:12], 12'b0};
    assign imm_j  = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    logic [NAME_W-1:0] d_name;
    logic [1:0]        d_type;
    logic [4:0]        d_rd, d_rs1, d_rs2;
    logic [31:0]       d_imm;
    logic              d_is_imm, d_is_pc, d_illegal, d_halt;

    always_comb begin
        d_name    = N_ADD;
        d_type    = T_REG;
        d_rd      = in_inst[11:7];
        d_rs1     = in_inst[19:15];
        d_rs2     = in_inst[24:20];
        d_imm     = 32'd0;
        d_is_imm  = 1'b0;
        d_is_pc   = 1'b0;
        d_illegal = 1'b0;
        d_halt    = 1'b0;

        case (opcode)
            7'b0110011: begin // OP
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  d_name = N_ADD;
                        3'b001:  d_name = N_SLL;
                        3'b010:  d_name = N_SLT;
                        3'b011:  d_name = N_SLTU;
                        3'b100:  d_name = N_XOR;
                        3'b101:  d_name = N_SRL;
                        3'b110:  d_name = N_OR;
                        default: d_name = N_AND;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    d_name = N_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    d_name = N_SRA;
`ifdef DECODE_RV32M_EN
                end else if (f7 == 7'b0000001) begin
                    case (f3)
                        3'b000:  d_name = N_MUL;
                        3'b001:  d_name = N_MULH;
                        3'b010:  d_name = N_MULHSU;
                        3'b011:  d_name = N_MULHU;
                        3'b100:  d_name = N_DIV;
                        3'b101:  d_name = N_DIVU;
                        3'b110:  d_name = N_REM;
                        default: d_name = N_REMU;
                    endcase
`endif
                end else begin
                    d_illegal = 1'b1;
                end
            end
            7'b0010011: begin // OP-IMM
                d_rs2    = 5'd0;
                d_imm    = imm_i;
                d_is_imm = 1'b1;
                case (f3)
                    3'b000:  d_name = N_ADDI;
                    3'b010:  d_name = N_SLTI;
                    3'b011:  d_name = N_SLTIU;
                    3'b100:  d_name = N_XORI;
                    3'b110:  d_name = N_ORI;
                    3'b111:  d_name = N_ANDI;
                    3'b001: begin
                        if (f7 == 7'b0000000) d_name = N_SLLI;
                        else                  d_illegal = 1'b1;
                    end
                    default: begin
                        if (f7 == 7'b0000000)      d_name = N_SRLI;
                        else if (f7 == 7'b0100000) d_name = N_SRAI;
                        else                       d_illegal = 1'b1;
                    end
                endcase
            end
            7'b0000011: begin // loads
                d_rs2    = 5'd0;
                d_imm    = imm_i;
                d_is_imm = 1'b1;
                case (f3)
                    3'b000:  d_name = N_LB;
                    3'b001:  d_name = N_LH;
                    3'b010:  d_name = N_LW;
                    3'b100:  d_name = N_LBU;
                    3'b101:  d_name = N_LHU;
                    default: d_illegal = 1'b1;
                endcase
            end
            7'b0100011: begin // stores
                d_type   = T_MEM;
                d_rd     = 5'd0;
                d_imm    = imm_s;
                d_is_imm = 1'b1;
                case (f3)
                    3'b000:  d_name = N_SB;
                    3'b001:  d_name = N_SH;
                    3'b010:  d_name = N_SW;
                    default: d_illegal = 1'b1;
                endcase
            end
            7'b1100011: begin // branches: immediate is the target offset, not operand B
                d_type = T_BR;
                d_rd   = 5'd0;
                d_imm  = imm_b;
                case (f3)
                    3'b000:  d_name = N_BEQ;
                    3'b001:  d_name = N_BNE;
                    3'b100:  d_name = N_BLT;
                    3'b101:  d_name = N_BGE;
                    3'b110:  d_name = N_BLTU;
                    3'b111:  d_name = N_BGEU;
                    default: d_illegal = 1'b1;
                endcase
            end
            7'b0110111: begin // LUI
                d_name   = N_LUI;
                d_rs1    = 5'd0;
                d_rs2    = 5'd0;
                d_imm    = imm_u;
                d_is_imm = 1'b1;
            end
            7'b0010111: begin // AUIPC
                d_name   = N_AUIPC;
                d_rs1    = 5'd0;
                d_rs2    = 5'd0;
                d_imm    = imm_u;
                d_is_imm = 1'b1;
                d_is_pc  = 1'b1;
            end
            7'b1101111: begin // JAL
                d_name   = N_JAL;
                d_rs1    = 5'd0;
                d_rs2    = 5'd0;
                d_imm    = imm_j;
                d_is_imm = 1'b1;
                d_is_pc  = 1'b1;
            end
            7'b1100111: begin // JALR
                d_name   = N_JALR;
                d_rs2    = 5'd0;
                d_imm    = imm_i;
                d_is_imm = 1'b1;
                if (f3 != 3'b000) d_illegal = 1'b1;
            end
            default: d_illegal = 1'b1;
        endcase

        // Illegal instructions travel down the pipe as a harmless NOP
        if (d_illegal) begin
            d_name   = N_ADD;
            d_type   = T_REG;
            d_rd     = 5'd0;
            d_rs1    = 5'd0;
            d_rs2    = 5'd0;
            d_imm    = 32'd0;
            d_is_imm = 1'b0;
            d_is_pc  = 1'b0;
        end

        if (in_inst == HALT_INST) begin
            d_type = T_DONE;
            d_halt = 1'b1;
        end
    end

    // ------------------------------------------------------------------ fifo
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               halt_seen;
    logic               enq, deq;

    assign in_ready  = (count < DEPTH_C) && !halt_seen;
    assign out_valid = (count != '0);
    assign enq       = in_valid && in_ready;
    assign deq       = out_valid && out_ready;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            halt_seen <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                count     <= '0;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                halt_seen <= 1'b0;
            end else begin
                if (enq) begin
                    mem[wr_ptr] <= {in_pc, d_name, d_type, d_rd, d_rs1, d_rs2, d_imm,
                                    d_is_imm, d_is_pc, d_illegal, d_halt};
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                    if (d_halt) halt_seen <= 1'b1;
                end
                if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
                case ({enq, deq})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    assign {out_pc, out_name, out_type, out_rd, out_rs1, out_rs2, out_imm,
            out_is_imm, out_is_pc, out_illegal, out_halt} = mem[rd_ptr];

endmodule

// File: tb/tb_decode_queue.sv
// Testbench for decode_queue: directed stimulus, a queue-based reference
// model compared every cycle, and literal expectations at key points.
module tb_decode_queue;

    localparam int DEPTH = 2;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        flush_in = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = 32'd0;
    logic [31:0] in_pc = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [5:0]  out_name;
    logic [1:0]  out_type;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [31:0] out_imm;
    logic        out_is_imm, out_is_pc, out_illegal, out_halt;

    decode_queue #(.DEPTH(DEPTH), .ADDR_W(32), .NAME_W(6)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_name(out_name), .out_type(out_type), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_is_imm(out_is_imm), .out_is_pc(out_is_pc),
        .out_illegal(out_illegal), .out_halt(out_halt)
    );

    always #5 clk_in = ~clk_in;

    localparam logic [1:0] T_REG = 2'd0, T_MEM = 2'd1, T_BR = 2'd2, T_DONE = 2'd3;
    localparam logic [5:0] N_ADD = 6'd0, N_SUB = 6'd1, N_SRA = 6'd7, N_ADDI = 6'd10,
                           N_SLLI = 6'd16, N_SRLI = 6'd17, N_SRAI = 6'd18,
                           N_LUI = 6'd33, N_AUIPC = 6'd34, N_JAL = 6'd35,
                           N_JALR = 6'd36, N_MUL = 6'd37;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  name;
        logic [1:0]  typ;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic        is_imm, is_pc, illegal, halt;
    } exp_t;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Name codes by mnemonic group, indexed with funct3
    function automatic logic [5:0] r_name(logic [2:0] f3);
        logic [5:0] t [8] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd8, 6'd9};
        return t[f3];
    endfunction
    function automatic logic [5:0] i_name(logic [2:0] f3);
        logic [5:0] t [8] = '{6'd10, 6'd16, 6'd11, 6'd12, 6'd13, 6'd17, 6'd14, 6'd15};
        return t[f3];
    endfunction

    function automatic exp_t m_decode(logic [31:0] i, logic [31:0] pc);
        exp_t r;
        logic signed [31:0] si;
        logic [31:0] sx, ii, is, ib, iu, ij;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        si  = i;
        sx  = i[31] ? 32'hffffffff : 32'h0;
        ii  = si >>> 20;
        is  = ((si >>> 25) << 5) | {27'd0, i[11:7]};
        ib  = (sx << 12) | ({31'd0, i[7]} << 11) | ({26'd0, i[30:25]} << 5) | ({28'd0, i[11:8]} << 1);
        iu  = i & 32'hfffff000;
        ij  = (sx << 20) | ({24'd0, i[19:12]} << 12) | ({31'd0, i[20]} << 11) | ({22'd0, i[30:21]} << 1);
        opc = i[6:0];
        f3  = i[14:12];
        f7  = i[31:25];
        r = '0;
        r.pc = pc; r.rd = i[11:7]; r.rs1 = i[19:15]; r.rs2 = i[24:20]; r.typ = T_REG;
        case (opc)
            7'h33: begin
                if (f7 == 7'h00) r.name = r_name(f3);
                else if (f7 == 7'h20 && f3 == 3'd0) r.name = N_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5) r.name = N_SRA;
`ifdef DECODE_RV32M_EN
                else if (f7 == 7'h01) r.name = 6'(N_MUL + f3);
`endif
                else r.illegal = 1'b1;
            end
            7'h13: begin
                r.rs2 = 0; r.imm = ii; r.is_imm = 1; r.name = i_name(f3);
                if (f3 == 3'd1 && f7 != 7'h00) r.illegal = 1;
                if (f3 == 3'd5) begin
                    if (f7 == 7'h20) r.name = N_SRAI;
                    else if (f7 != 7'h00) r.illegal = 1;
                end
            end
            7'h03: begin
                r.rs2 = 0; r.imm = ii; r.is_imm = 1;
                if (f3 == 3 || f3 > 5) r.illegal = 1;
                else r.name = (f3 < 3) ? 6'(19 + f3) : 6'(22 + f3 - 4);
            end
            7'h23: begin
                r.typ = T_MEM; r.rd = 0; r.imm = is; r.is_imm = 1;
                if (f3 > 2) r.illegal = 1; else r.name = 6'(24 + f3);
            end
            7'h63: begin
                r.typ = T_BR; r.rd = 0; r.imm = ib;
                if (f3 == 2 || f3 == 3) r.illegal = 1;
                else r.name = (f3 < 2) ? 6'(27 + f3) : 6'(29 + f3 - 4);
            end
            7'h37: begin r.name = N_LUI;   r.rs1 = 0; r.rs2 = 0; r.imm = iu; r.is_imm = 1; end
            7'h17: begin r.name = N_AUIPC; r.rs1 = 0; r.rs2 = 0; r.imm = iu; r.is_imm = 1; r.is_pc = 1; end
            7'h6f: begin r.name = N_JAL;   r.rs1 = 0; r.rs2 = 0; r.imm = ij; r.is_imm = 1; r.is_pc = 1; end
            7'h67: begin
                r.name = N_JALR; r.rs2 = 0; r.imm = ii; r.is_imm = 1;
                if (f3 != 0) r.illegal = 1;
            end
            default: r.illegal = 1;
        endcase
        if (r.illegal) begin
            r.name = N_ADD; r.typ = T_REG; r.rd = 0; r.is_imm = 0;
        end
        if (i == 32'h0ff00513) begin r.typ = T_DONE; r.halt = 1; end
        return r;
    endfunction

    // Reference model: FIFO of decoded entries plus a halt flag
    exp_t mq [$];
    bit   m_halt = 1'b0;

    always @(posedge clk_in or negedge rst_in) begin
        bit e, d;
        if (!rst_in) begin
            mq.delete();
            m_halt = 1'b0;
        end else if (rdy_in) begin
            if (flush_in) begin
                mq.delete();
                m_halt = 1'b0;
            end else begin
                e = in_valid && (mq.size() < DEPTH) && !m_halt;
                d = out_ready && (mq.size() > 0);
                if (d) void'(mq.pop_front());
                if (e) begin
                    mq.push_back(m_decode(in_inst, in_pc));
                    if (mq[$].halt) m_halt = 1'b1;
                end
            end
        end
    end

    exp_t h;
    always @(negedge clk_in) begin
        if (rst_in && started) begin
            chk("out_valid", out_valid, mq.size() > 0);
            chk("in_ready", in_ready, (mq.size() < DEPTH) && !m_halt);
            if (mq.size() > 0) begin
                h = mq[0];
                chk("pc", out_pc, h.pc);
                chk("name", out_name, h.name);
                chk("type", out_type, h.typ);
                chk("rd", out_rd, h.rd);
                chk("is_imm", out_is_imm, h.is_imm);
                chk("illegal", out_illegal, h.illegal);
                chk("halt", out_halt, h.halt);
                if (!h.illegal) begin
                    chk("rs1", out_rs1, h.rs1);
                    chk("rs2", out_rs2, h.rs2);
                    chk("imm", out_imm, h.imm);
                    chk("is_pc", out_is_pc, h.is_pc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(logic [31:0] inst, logic [31:0] pc);
        bit ok;
        int n;
        in_valid = 1'b1; in_inst = inst; in_pc = pc;
        ok = 1'b0; n = 0;
        while (!ok && n < 50) begin
            ok = in_ready;
            step();
            n++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1 (pc %0h)", pc);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (3) step();
        out_ready = 1'b0;
    endtask

    logic [31:0] vec [14] = '{
        32'h402081b3, 32'h407352b3, 32'h40315093, 32'hff812203, 32'h0050a623,
        32'h123453b7, 32'hfffff417, 32'h004280e7, 32'h00000073, 32'h00003003,
        32'h40001093, 32'h0020e863, 32'h40209033, 32'h00a00593
    };

    initial begin
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_name", out_name, 0);
        chk("rst_out_imm", out_imm, 0);
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        started = 1'b1;
        step();

        // Single addi, latency 1
        send(32'h00500093, 32'h0);
        chk("addi_valid", out_valid, 1);
        chk("addi_name", out_name, N_ADDI);
        chk("addi_rd", out_rd, 1);
        chk("addi_rs1", out_rs1, 0);
        chk("addi_imm", out_imm, 5);
        chk("addi_is_imm", out_is_imm, 1);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("addi_deq_valid", out_valid, 0);

        // Backpressure: third offer waits while FIFO full
        send(32'h00100093, 32'h100);
        send(32'h00200113, 32'h104);
        chk("full_in_ready", in_ready, 0);
        in_valid = 1'b1; in_inst = 32'h00300193; in_pc = 32'h108;
        repeat (3) step();
        chk("pending_in_ready", in_ready, 0);
        out_ready = 1'b1;
        chk("order_0", out_pc, 32'h100);
        step();
        chk("order_1", out_pc, 32'h104);
        send(32'h00300193, 32'h108);
        chk("order_2", out_pc, 32'h108);
        step();
        chk("drained_valid", out_valid, 0);
        out_ready = 1'b0;

        // Branch and jump immediates
        send(32'hfe000ee3, 32'h200);
        chk("beq_type", out_type, T_BR);
        chk("beq_imm", out_imm, 32'hfffffffc);
        chk("beq_is_imm", out_is_imm, 0);
        send(32'h008000ef, 32'h204);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("jal_imm", out_imm, 8);
        chk("jal_is_pc", out_is_pc, 1);
        chk("jal_rd", out_rd, 1);
        drain();

        // Flush with full FIFO and an offered instruction
        send(32'h00100093, 32'h300);
        send(32'h00200113, 32'h304);
        in_valid = 1'b1; in_inst = 32'h00700393; in_pc = 32'h308; flush_in = 1'b1;
        step();
        flush_in = 1'b0; in_valid = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        // Flush where the enqueue would otherwise fire
        send(32'h00100093, 32'h310);
        in_valid = 1'b1; in_inst = 32'h00700393; in_pc = 32'h314; flush_in = 1'b1;
        out_ready = 1'b1;
        step();
        flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("flush2_valid", out_valid, 0);
        step();
        chk("flush2_stay_empty", out_valid, 0);
        send(32'h00900493, 32'h318);
        chk("after_flush_pc", out_pc, 32'h318);
        drain();

        // Halt
        send(32'h0ff00513, 32'h400);
        chk("halt_type", out_type, T_DONE);
        chk("halt_flag", out_halt, 1);
        chk("halt_in_ready", in_ready, 0);
        in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h404;
        repeat (3) step();
        in_valid = 1'b0;
        drain();
        chk("halt_blocks_empty", in_ready, 0);
        flush_in = 1'b1; step(); flush_in = 1'b0;
        chk("halt_flush_ready", in_ready, 1);

        // RV32M encoding
        send(32'h02208033, 32'h500);
`ifdef DECODE_RV32M_EN
        chk("mul_name", out_name, N_MUL);
        chk("mul_illegal", out_illegal, 0);
`else
        chk("mul_illegal", out_illegal, 1);
        chk("mul_rd", out_rd, 0);
`endif
        drain();

        // Mixed decode vectors with alternating backpressure
        for (int k = 0; k < 14; k++) begin
            out_ready = k[0];
            send(vec[k], 32'h600 + 32'(k) * 4);
        end
        drain();

        // rdy_in low freezes everything
        send(32'h00100093, 32'h700);
        send(32'h00200113, 32'h704);
        rdy_in = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h00300193; in_pc = 32'h708;
        repeat (3) step();
        chk("hold_pc", out_pc, 32'h700);
        chk("hold_valid", out_valid, 1);
        rdy_in = 1'b1; in_valid = 1'b0;
        drain();

        // Asynchronous reset mid-operation
        send(32'h00100093, 32'h800);
        #2 rst_in = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_pc", out_pc, 0);
        step();
        rst_in = 1'b1;
        step();
        send(32'h00500093, 32'h900);
        chk("post_rst_pc", out_pc, 32'h900);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
